if_fetch_unit: RTL and testbench

- Instruction-fetch stage feeding the decode stage.
- Owns the PC and issues word fetches to a variable-latency instruction memory using a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and applies jump redirects from downstream.
- On a redirect it flushes the FIFO and discards any stale in-flight responses.

---
 rtl/if_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/gnt/rvalid word fetches and buffers responses for decode.
// Define IF_ALIGN_CHECK_EN to trap misaligned jump targets in a HALT state and raise fetch_exc_o.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_addr_o,
    output logic [31:0] id_data_o,
    output logic        fetch_exc_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 2);
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1} state_e;
`endif

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic            pend_q, pend_d;
    logic [31:0]     pend_addr_q, pend_addr_d;
    logic            pend_drop_q, pend_drop_d;

    logic [31:0]     addr_mem [FIFO_DEPTH];
    logic [31:0]     data_mem [FIFO_DEPTH];

    logic            gnt_fire;
    logic            gnt_stale;
    logic            rsp_keep;
    logic            push_we;
    logic            pop;
    logic            issue_ok;
    logic            jump_misaligned;
    logic [CW-1:0]   live_out;
    logic [31:0]     req_addr;
    logic [31:0]     jump_tgt;

`ifdef IF_ALIGN_CHECK_EN
    logic            exc_q, exc_d;
    assign jump_misaligned = (jump_addr_i[1:0] != 2'b00);
    assign jump_tgt        = jump_addr_i;
    assign fetch_exc_o     = exc_q;
`else
    assign jump_misaligned = 1'b0;
    assign jump_tgt        = jump_addr_i & 32'hFFFF_FFFC;
    assign fetch_exc_o     = 1'b0;
`endif

    assign live_out   = out_q - drop_q;
    assign issue_ok   = (state_q == FETCH) &&
                        (({1'b0, cnt_q} + {1'b0, live_out}) < DEPTH_C);
    // An ungranted request keeps its address even after a redirect moved the PC.
    assign imem_req_o  = pend_q | issue_ok;
    assign req_addr    = pend_q ? pend_addr_q : pc_q;
    assign imem_addr_o = imem_req_o ? req_addr : 32'h0;

    assign gnt_fire  = imem_req_o & imem_gnt_i;
    assign gnt_stale = gnt_fire & pend_q & pend_drop_q;
    assign rsp_keep  = imem_rvalid_i & (drop_q == '0);
    assign push_we   = rsp_keep & ~jump_en_i;
    assign pop       = id_valid_o & ~stall_i & ~jump_en_i;

    assign id_valid_o = (cnt_q != '0);
    assign id_addr_o  = id_valid_o ? addr_mem[rd_q] : 32'h0;
    assign id_data_o  = id_valid_o ? data_mem[rd_q] : 32'h0;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        resp_pc_d   = resp_pc_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_drop_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        exc_d       = exc_q;
`endif
        out_d = out_q + CW'(gnt_fire) - CW'(imem_rvalid_i);

        if (imem_req_o && !imem_gnt_i) begin
            pend_d      = 1'b1;
            pend_addr_d = req_addr;
            pend_drop_d = pend_drop_q | jump_en_i;
        end

        if (state_q == IDLE) begin
            state_d = FETCH;
        end

        if (jump_en_i) begin
            // Everything already granted is stale; a still-pending request is added at its grant.
            drop_d    = out_d;
            pc_d      = jump_tgt;
            resp_pc_d = jump_tgt;
            cnt_d     = '0;
            rd_d      = '0;
            wr_d      = '0;
            state_d   = FETCH;
`ifdef IF_ALIGN_CHECK_EN
            exc_d     = jump_misaligned;
            if (jump_misaligned) begin
                state_d = HALT;
            end
`endif
        end else begin
            drop_d = drop_q - CW'(imem_rvalid_i && (drop_q != '0)) + CW'(gnt_stale);
            if (gnt_fire && !gnt_stale) begin
                pc_d = pc_q + 32'd4;
            end
            if (push_we) begin
                wr_d      = wr_q + AW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push_we) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            out_q       <= '0;
            drop_q      <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= 32'h0;
            pend_drop_q <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            exc_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            resp_pc_q   <= resp_pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_drop_q <= pend_drop_d;
`ifdef IF_ALIGN_CHECK_EN
            exc_q       <= exc_d;
`endif
        end
    end

    // Buffer storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push_we) begin
            addr_mem[wr_q] <= resp_pc_q;
            data_mem[wr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory responder with configurable grant and latency, vector table plus corner sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_addr_o;
    logic [31:0] id_data_o;
    logic        fetch_exc_o;

    logic        gnt_en;
    int          mem_lat;
    int          tests = 0;
    int          fails = 0;

    typedef struct { logic [31:0] a; int wt; } rsp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } pop_t;
    typedef struct { logic [31:0] tgt; logic [31:0] e0; logic [31:0] e1; } vec_t;

    rsp_t        mq[$];
    pop_t        pops[$];
    logic [31:0] grants[$];
    logic        gnt_seen;
    logic [31:0] gnt_addr;

    if_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_addr_o     (id_addr_o),
        .id_data_o     (id_data_o),
        .fetch_exc_o   (fetch_exc_o)
    );

    always #5 clk = ~clk;

    assign imem_gnt_i = imem_req_o & gnt_en;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    always @(negedge clk) begin
        gnt_seen = rst_n && imem_req_o && imem_gnt_i;
        gnt_addr = imem_addr_o;
        if (gnt_seen) grants.push_back(imem_addr_o);
        if (rst_n && id_valid_o && !stall_i && !jump_en_i) pops.push_back('{id_addr_o, id_data_o});
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            imem_rvalid_i <= 1'b0;
            imem_rdata_i  <= 32'h0;
        end else begin
            if (imem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
            foreach (mq[i]) mq[i].wt = mq[i].wt - 1;
            if (gnt_seen) mq.push_back('{gnt_addr, mem_lat - 1});
            if (mq.size() > 0 && mq[0].wt <= 0) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= mdata(mq[0].a);
            end else begin
                imem_rvalid_i <= 1'b0;
                imem_rdata_i  <= 32'h0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        stall_i     = 1'b0;
        jump_en_i   = 1'b0;
        jump_addr_i = 32'h0;
        gnt_en      = 1'b1;
        mem_lat     = 1;
        step();
        step();
        chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
        chk("rst_idaddr", id_addr_o, 32'h0);
        chk("rst_iddata", id_data_o, 32'h0);
        chk("rst_exc",   {31'h0, fetch_exc_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        grants.delete();
        pops.delete();
    endtask

    task automatic jump(input logic [31:0] tgt);
        jump_en_i   = 1'b1;
        jump_addr_i = tgt;
        step();
        jump_en_i   = 1'b0;
        jump_addr_i = 32'h0;
    endtask

    task automatic wait_pops(input int n, input int max_cyc);
        int k = 0;
        while (pops.size() < n && k < max_cyc) begin
            step();
            k++;
        end
        tests++;
        if (pops.size() < n) begin
            fails++;
            $display("FAIL wait_pops: got %0d instructions, expected %0d", pops.size(), n);
        end
    endtask

    function automatic logic [31:0] pop_a(input int i);
        return (i < pops.size()) ? pops[i].a : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pop_d(input int i);
        return (i < pops.size()) ? pops[i].d : 32'hDEAD_DEAD;
    endfunction

    initial begin
        vec_t tbl[5];
        int   ntbl;
        tbl[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2004};
`ifdef IF_ALIGN_CHECK_EN
        ntbl = 3;
`else
        tbl[3] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104};
        tbl[4] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};
        ntbl = 5;
`endif

        // Streaming with immediate grant and one-cycle response.
        do_reset();
        chk("idle_noreq", {31'h0, imem_req_o}, 32'h0);
        step();
        chk("first_req",  {31'h0, imem_req_o}, 32'h1);
        chk("first_addr", imem_addr_o, 32'h0);
        wait_pops(6, 60);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stream_addr%0d", i), pop_a(i), 32'(4 * i));
            chk($sformatf("stream_data%0d", i), pop_d(i), mdata(32'(4 * i)));
        end

        // Stall holds the buffer full and throttles requests.
        do_reset();
        stall_i = 1'b1;
        repeat (10) step();
        chk("stall_grants", 32'(grants.size()), 32'd2);
        chk("stall_noreq",  {31'h0, imem_req_o}, 32'h0);
        chk("stall_valid",  {31'h0, id_valid_o}, 32'h1);
        chk("stall_head",   id_addr_o, 32'h0);
        stall_i = 1'b0;
        wait_pops(4, 60);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("unstall_addr%0d", i), pop_a(i), 32'(4 * i));
        end

        // Jump with two responses in flight at latency 3.
        do_reset();
        mem_lat = 3;
        repeat (3) step();
        chk("lat3_inflight", 32'(grants.size()), 32'd2);
        chk("lat3_novalid",  {31'h0, id_valid_o}, 32'h0);
        jump(32'h0000_0100);
        pops.delete();
        chk("lat3_flush", {31'h0, id_valid_o}, 32'h0);
        wait_pops(2, 60);
        chk("lat3_addr0", pop_a(0), 32'h0000_0100);
        chk("lat3_data0", pop_d(0), mdata(32'h0000_0100));
        chk("lat3_addr1", pop_a(1), 32'h0000_0104);

        // Jump hits a request whose grant is withheld.
        do_reset();
        gnt_en = 1'b0;
        step();
        chk("pend_req",  {31'h0, imem_req_o}, 32'h1);
        chk("pend_addr", imem_addr_o, 32'h0);
        jump(32'h0000_0200);
        chk("pend_hold_req",  {31'h0, imem_req_o}, 32'h1);
        chk("pend_hold_addr", imem_addr_o, 32'h0);
        repeat (3) step();
        chk("pend_hold_addr2", imem_addr_o, 32'h0);
        gnt_en = 1'b1;
        step();
        chk("pend_gnt_old", (grants.size() > 0) ? grants[0] : 32'hDEAD_DEAD, 32'h0);
        chk("pend_new_req",  {31'h0, imem_req_o}, 32'h1);
        chk("pend_new_addr", imem_addr_o, 32'h0000_0200);
        wait_pops(1, 60);
        chk("pend_addr0", pop_a(0), 32'h0000_0200);
        chk("pend_data0", pop_d(0), mdata(32'h0000_0200));

        // Jump coinciding with a response and a decode pop.
        do_reset();
        repeat (3) step();
        chk("coinc_pre_valid", {31'h0, id_valid_o}, 32'h1);
        chk("coinc_pre_head",  id_addr_o, 32'h0);
        jump(32'h0000_0400);
        pops.delete();
        chk("coinc_empty", {31'h0, id_valid_o}, 32'h0);
        chk("coinc_req",   {31'h0, imem_req_o}, 32'h1);
        chk("coinc_addr",  imem_addr_o, 32'h0000_0400);
        wait_pops(1, 60);
        chk("coinc_addr0", pop_a(0), 32'h0000_0400);
        chk("coinc_data0", pop_d(0), mdata(32'h0000_0400));

        // Jump target table, including the address wrap.
        for (int v = 0; v < ntbl; v++) begin
            do_reset();
            repeat (4) step();
            jump(tbl[v].tgt);
            pops.delete();
            chk($sformatf("tbl%0d_exc", v), {31'h0, fetch_exc_o}, 32'h0);
            wait_pops(2, 60);
            chk($sformatf("tbl%0d_addr0", v), pop_a(0), tbl[v].e0);
            chk($sformatf("tbl%0d_data0", v), pop_d(0), mdata(tbl[v].e0));
            chk($sformatf("tbl%0d_addr1", v), pop_a(1), tbl[v].e1);
        end

`ifdef IF_ALIGN_CHECK_EN
        // Misaligned target halts fetch until an aligned jump.
        do_reset();
        repeat (4) step();
        jump(32'h0000_0102);
        chk("halt_exc", {31'h0, fetch_exc_o}, 32'h1);
        grants.delete();
        repeat (10) step();
        chk("halt_grants", 32'(grants.size()), 32'd0);
        chk("halt_noreq",  {31'h0, imem_req_o}, 32'h0);
        chk("halt_novalid", {31'h0, id_valid_o}, 32'h0);
        chk("halt_exc_held", {31'h0, fetch_exc_o}, 32'h1);
        jump(32'h0000_0300);
        chk("resume_exc", {31'h0, fetch_exc_o}, 32'h0);
        pops.delete();
        wait_pops(1, 60);
        chk("resume_addr0", pop_a(0), 32'h0000_0300);
        chk("resume_data0", pop_d(0), mdata(32'h0000_0300));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
